// File: rtl/fifo_rd_streamer.sv
// Read-side consumer of the async FIFO: pops a counted burst and replays it on a valid/ready stream.
// Optional FIFO_RD_STATS_EN build adds stall_cnt / xfer_cnt statistics ports.
//
// state | meaning
// IDLE  | waiting for start; len sampled here
// RUN   | issuing pops under output-queue credit
// DRAIN | all pops issued; waiting for the last word to be accepted
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_rd_streamer #(
  parameter int W     = 8,
  parameter int LEN_W = 16,
  parameter int OQ_D  = 2
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             r_en,
  input  logic             empty,
  input  logic [W-1:0]     d_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [31:0]      xfer_cnt
`endif
);

  localparam int PW  = (OQ_D > 1) ? $clog2(OQ_D) : 1;
  localparam int CW  = $clog2(OQ_D + 1);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_issue_q, rem_issue_d;
  logic [LEN_W-1:0] rem_acc_q, rem_acc_d;
  logic [W-1:0]     mem_q [OQ_D];
  logic [W-1:0]     mem_d [OQ_D];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             deq;
  logic [CW1-1:0]   credit_use;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OQ_D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign m_valid = (occ_q != '0);
  assign m_data  = m_valid ? mem_q[head_q] : '0;
  assign deq     = m_valid & m_ready;
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);

  // Credit counts the word already in flight, so a pop is only issued when its capture slot is guaranteed.
  assign credit_use = CW1'(occ_q) + CW1'(inflight_q) - CW1'(deq);
  assign r_en = (state_q == S_RUN) && !empty && (rem_issue_q != '0) &&
                (credit_use < CW1'(OQ_D));

  always_comb begin
    state_d     = state_q;
    rem_issue_d = rem_issue_q;
    rem_acc_d   = rem_acc_q;
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    inflight_d  = r_en;
    occ_d       = occ_q + CW'(inflight_q) - CW'(deq);

    if (inflight_q) begin
      mem_d[tail_q] = d_out;
      tail_d        = ptr_inc(tail_q);
    end
    if (deq) head_d = ptr_inc(head_q);

    if (r_en && rem_issue_q != '0) rem_issue_d = rem_issue_q - LEN_W'(1);
    if (deq && rem_acc_q != '0)    rem_acc_d   = rem_acc_q - LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_issue_d = len;
          rem_acc_d   = len;
          state_d     = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (r_en && rem_issue_q == LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: if (rem_acc_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q     <= S_IDLE;
      rem_issue_q <= '0;
      rem_acc_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      for (int i = 0; i < OQ_D; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rem_issue_q <= rem_issue_d;
      rem_acc_q   <= rem_acc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      mem_q       <= mem_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_RUN && empty && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
    xfer_cnt_d = xfer_cnt_q + 32'(deq);
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      stall_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: 1-cycle-latency FIFO model, transfer vector table, directed reset
// sequence and randomized transfers checked against an in-order word log.
module tb_fifo_rd_streamer;
  localparam int W     = 8;
  localparam int LEN_W = 16;
  localparam int OQ_D  = 2;

  logic             r_clk = 1'b0;
  logic             r_rst, start, m_ready;
  logic [LEN_W-1:0] len;
  logic             busy, done, r_en, empty, m_valid;
  logic [W-1:0]     d_out = '0;
  logic [W-1:0]     m_data;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]      stall_cnt;
  logic [31:0]      xfer_cnt;
`endif

  always #5 r_clk = ~r_clk;

  fifo_rd_streamer #(.W(W), .LEN_W(LEN_W), .OQ_D(OQ_D)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .start(start), .len(len), .busy(busy), .done(done),
    .r_en(r_en), .empty(empty), .d_out(d_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data)
`ifdef FIFO_RD_STATS_EN
    , .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  // FIFO model: the push log doubles as the expected stream order
  logic [W-1:0] fmem [4096];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign empty = (wr_ptr == rd_ptr);

  always @(posedge r_clk) begin
    if (r_en && !empty) begin
      d_out  <= fmem[rd_ptr % 4096];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int fails  = 0;
  int seq_val = 0;
  int cyc = 0, acc_cnt = 0, ren_cnt = 0, done_cnt = 0, mv_cnt = 0;
  int exp_idx = 0, acc_since_rst = 0, start_cyc = 0;
  bit resync = 0, prev_stall = 0;
  logic [W-1:0] prev_data = '0;
  int acc_cyc[$];

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_word(input bit rnd);
    fmem[wr_ptr % 4096] = rnd ? W'($urandom_range(0, 255)) : W'(seq_val);
    seq_val++;
    wr_ptr++;
  endtask

  task automatic monitor();
    int outstanding;
    if (r_rst) begin
      resync = 1;
      prev_stall = 0;
      acc_since_rst = 0;
      return;
    end
    if (resync) begin
      exp_idx = rd_ptr;
      resync = 0;
    end
    outstanding = rd_ptr - exp_idx - int'(m_valid && m_ready);
    if (r_en) begin
      ren_cnt++;
      chk_eq("ren_while_empty", empty, 0);
      chk_eq("credit_ok", outstanding < OQ_D, 1);
    end
    if (prev_stall) begin
      chk_eq("hold_valid", m_valid, 1);
      chk_eq("hold_data", m_data, prev_data);
    end
    if (m_valid) mv_cnt++;
    if (m_valid && m_ready) begin
      chk_eq("data", m_data, fmem[exp_idx % 4096]);
      exp_idx++;
      acc_cnt++;
      acc_since_rst++;
      acc_cyc.push_back(cyc);
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    if (done) done_cnt++;
  endtask

  task automatic tick();
    @(negedge r_clk);
    cyc++;
    monitor();
    @(posedge r_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_ren"}, r_en, 0);
    chk_eq({tag, "_mvalid"}, m_valid, 0);
    chk_eq({tag, "_mdata"}, m_data, 0);
  endtask

  // One transfer; counts are compared as deltas of the monitor tallies.
  task automatic run_xfer(input string name, input int n, input int pre, input int late,
                          input logic [15:0] mask, input bit rnd, input bit poke,
                          input int exp_acc, input int exp_pops, input int exp_done);
    int b_acc, b_ren, b_done, b_mv, rel;
    bit was_empty;
    b_acc = acc_cnt; b_ren = ren_cnt; b_done = done_cnt; b_mv = mv_cnt;
    for (int i = 0; i < pre; i++) push_word(rnd);
    was_empty = (pre == 0) && (wr_ptr == rd_ptr);
    start   = 1'b1;
    len     = LEN_W'(n);
    m_ready = rnd ? ($urandom_range(0, 99) < 70) : mask[0];
    tick();
    start_cyc = cyc;
    rel = 1;
    while (done_cnt == b_done && rel < 500) begin
      m_ready = rnd ? ($urandom_range(0, 99) < 70) : ((rel < 16) ? mask[rel] : 1'b1);
      if (rel == 12 && late > 0) begin
        if (was_empty) chk_eq({name, "_ren_while_empty_fifo"}, ren_cnt - b_ren, 0);
        for (int i = 0; i < late; i++) push_word(rnd);
      end
      if (poke && rel == 4) begin
        start = 1'b1;
        len   = LEN_W'(3);
      end else begin
        start = 1'b0;
      end
      tick();
      rel++;
    end
    chk_eq({name, "_timeout"}, done_cnt != b_done, 1);
    m_ready = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_eq({name, "_accepted"}, acc_cnt - b_acc, exp_acc);
    chk_eq({name, "_pops"}, ren_cnt - b_ren, exp_pops);
    chk_eq({name, "_done_pulses"}, done_cnt - b_done, exp_done);
    chk_eq({name, "_busy_end"}, busy, 0);
    if (exp_acc == 0) chk_eq({name, "_no_valid"}, mv_cnt - b_mv, 0);
  endtask

  typedef struct {
    int          n;
    int          pre;
    int          late;
    logic [15:0] mask;
    bit          poke;
    int          exp_acc;
    int          exp_pops;
    int          exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int b_acc, b_rd, b_done, n, pre;
    // len=0, len=1, ready gap on cycles 3-7, empty FIFO filled late, start while busy, mixed
    vecs[0] = '{n: 0, pre: 0, late: 0, mask: 16'hFFFF, poke: 0, exp_acc: 0, exp_pops: 0, exp_done: 1};
    vecs[1] = '{n: 1, pre: 1, late: 0, mask: 16'hFFFF, poke: 0, exp_acc: 1, exp_pops: 1, exp_done: 1};
    vecs[2] = '{n: 8, pre: 8, late: 0, mask: 16'hFF07, poke: 0, exp_acc: 8, exp_pops: 8, exp_done: 1};
    vecs[3] = '{n: 4, pre: 0, late: 4, mask: 16'hFFFF, poke: 0, exp_acc: 4, exp_pops: 4, exp_done: 1};
    vecs[4] = '{n: 6, pre: 6, late: 0, mask: 16'hFFFF, poke: 1, exp_acc: 6, exp_pops: 6, exp_done: 1};
    vecs[5] = '{n: 5, pre: 2, late: 3, mask: 16'h5555, poke: 0, exp_acc: 5, exp_pops: 5, exp_done: 1};
    vecs[6] = '{n: 3, pre: 3, late: 0, mask: 16'h0000, poke: 0, exp_acc: 3, exp_pops: 3, exp_done: 1};

    r_rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;
    @(posedge r_clk); #1;
    tick();
    check_reset_vals("reset");
    r_rst = 1'b0;
    tick();

    // 0..9 streamed back-to-back; first word 2 cycles after the start-sampling edge
    run_xfer("seq10", 10, 10, 0, 16'hFFFF, 0, 0, 10, 10, 1);
    chk_eq("seq10_first_latency", acc_cyc[0] - start_cyc, 3);
    chk_eq("seq10_back_to_back", acc_cyc[9] - acc_cyc[0], 9);
    chk_eq("seq10_last_word", fmem[9], 9);

    foreach (vecs[i])
      run_xfer($sformatf("vec%0d", i), vecs[i].n, vecs[i].pre, vecs[i].late, vecs[i].mask,
               0, vecs[i].poke, vecs[i].exp_acc, vecs[i].exp_pops, vecs[i].exp_done);

    // Reset while the queue is full and the stream is stalled
    for (int i = 0; i < 10; i++) push_word(0);
    b_rd = rd_ptr; b_acc = acc_cnt;
    start = 1'b1; len = LEN_W'(10); m_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_eq("rst_queue_full_valid", m_valid, 1);
    chk_eq("rst_pops_before_reset", rd_ptr - b_rd, OQ_D);
    r_rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    r_rst = 1'b0;
    m_ready = 1'b1;
    b_done = done_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk_eq("midrst_no_done", done_cnt - b_done, 0);
    chk_eq("midrst_no_accept", acc_cnt - b_acc, 0);
    run_xfer("post_rst", 2, 0, 0, 16'hFFFF, 0, 0, 2, 2, 1);

    for (int t = 0; t < 20; t++) begin
      n   = $urandom_range(0, 12);
      pre = $urandom_range(0, n);
      run_xfer($sformatf("rnd%0d", t), n, pre, n - pre, 16'hFFFF, 1, (n >= 4), n, n, 1);
    end

`ifdef FIFO_RD_STATS_EN
    chk_eq("xfer_cnt_total", xfer_cnt, acc_since_rst);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
